mod_counter: RTL and testbench
==============================

MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 6: counter width in bits.
REQ-002 SHALL have parameter MAX, default 15: terminal count; legal range 1 to 2**WIDTH-1.
REQ-003 SHALL have parameter WRAP, default 1: 1 = wrap at the boundary, 0 = saturate at the boundary.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: count enable.
REQ-007 SHALL have port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port clr, input, 1 bit: synchronous clear of count.
REQ-009 SHALL have port load, input, 1 bit: parallel load strobe.
REQ-010 SHALL have port load_val, input, WIDTH bits: parallel load value.
REQ-011 SHALL have port ovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-012 SHALL have port count, output, WIDTH bits: current count, registered.
REQ-013 SHALL have port tc, output, 1 bit: combinational boundary-event indicator.
REQ-014 SHALL have port ovf, output, 1 bit: sticky boundary-event flag, registered.

Function
REQ-015 SHALL apply per-cycle priority rst_n low > clr > load > en; with none active, count holds.
REQ-016 SHALL set count to 0 on the next edge when clr=1, regardless of load and en.
REQ-017 SHALL set count to load_val when load=1 and clr=0, or to MAX if load_val > MAX.
REQ-018 SHALL, when en=1, up=1, count<MAX (no clr/load), set count to count+1; with up=0 and count>0, set count to count-1.
REQ-019 SHALL, on an up-boundary event (en=1, up=1, count==MAX, no clr/load), set count to 0 if WRAP=1, else hold MAX.
REQ-020 SHALL, on a down-boundary event (en=1, up=0, count==0, no clr/load), set count to MAX if WRAP=1, else hold 0.
REQ-021 SHALL drive tc=1 in exactly the cycles where REQ-019 or REQ-020 applies; zero latency, combinational from count/en/up/clr/load.
REQ-022 SHALL set ovf to 1 on the edge ending a tc=1 cycle, and hold it until cleared.
REQ-023 SHALL clear ovf on an edge where ovf_clr=1 or clr=1, except that a simultaneous tc=1 wins and ovf becomes 1.
REQ-024 SHALL never hold count > MAX in any reachable state.
REQ-025 SHALL perform next-value arithmetic at WIDTH+1 bits so that MAX = 2**WIDTH-1 produces no unintended truncation.
REQ-026 SHALL reject illegal parameters (MAX=0, MAX >= 2**WIDTH, WRAP not 0/1) at elaboration.

Reset
REQ-027 SHALL, on an edge with rst_n=0, set count=0 and ovf=0, overriding all other inputs.
REQ-028 SHALL allow reset mid-count; normal operation resumes on the first edge with rst_n=1.
REQ-029 SHALL hold tc=0 while rst_n=0.

Configuration
REQ-030 SHALL use macro MOD_COUNTER_ASSERT_EN: when defined, the block compiles embedded assertions: count<=MAX always, count==0 and ovf==0 one cycle after reset, tc implies the REQ-019/020 next value, and every count change is ±1, a wrap, a clear or a load.
REQ-031 SHALL, without MOD_COUNTER_ASSERT_EN, contain no assertion code and have identical port behaviour.

Structure
REQ-032 SHALL place in shared package mod_counter_pkg: the WRAP/SATURATE mode constants and the priority-decode enum (IDLE, CLR, LOAD, STEP).
REQ-033 SHALL implement next-value and boundary detection as one combinational sub-module, mod_counter_next; flops stay in mod_counter.

Verification
REQ-034 SHALL cover: defaults, en=1, up=1 for 16 cycles from reset -> count 0..15 then 0; tc=1 only at count=15; ovf=1 after that edge.
REQ-035 SHALL cover: WRAP=0, up=0 from count=0 for 3 cycles -> count stays 0, tc=1 each cycle, ovf=1.
REQ-036 SHALL cover: load=1, load_val=40 with MAX=15 -> count=15; same cycle with clr=1 -> count=0.
REQ-037 SHALL cover: ovf=1, then ovf_clr=1 with tc=1 in the same cycle -> ovf stays 1; next cycle ovf_clr=1, tc=0 -> ovf=0.
REQ-038 SHALL cover: WIDTH=4, MAX=15, up count through 15 -> wraps to 0 with no X or truncation error.
REQ-039 SHALL cover: rst_n=0 at count=9 with en=1 -> count=0, ovf=0, tc=0 next edge; counting resumes 1,2,... after release.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the mod_counter block: boundary-mode constants and the
// per-cycle priority decode used by the next-value logic.
package mod_counter_pkg;

  localparam int unsigned MODE_SATURATE = 0;
  localparam int unsigned MODE_WRAP     = 1;

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    LOAD,
    STEP
  } op_e;

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and boundary-event (tc) logic for mod_counter.
// Arithmetic is one bit wider than the count so MAX = 2**WIDTH-1 cannot overflow.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 15,
  parameter int unsigned WRAP  = 1
) (
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_count,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc
);

  localparam int unsigned     EW      = WIDTH + 1;
  localparam logic [EW-1:0]   MAX_EXT = EW'(MAX);

  logic [EW-1:0] w_count_ext;
  logic [EW-1:0] w_load_ext;
  logic [EW-1:0] w_next_ext;
  logic          w_at_max;
  logic          w_at_zero;
  op_e           w_op;

  assign w_count_ext = {1'b0, i_count};
  assign w_load_ext  = {1'b0, i_load_val};
  assign w_at_max    = (w_count_ext == MAX_EXT);
  assign w_at_zero   = (w_count_ext == '0);

  // Priority decode: clr > load > en
  always_comb begin
    w_op = IDLE;
    if (i_clr) begin
      w_op = CLR;
    end else if (i_load) begin
      w_op = LOAD;
    end else if (i_en) begin
      w_op = STEP;
    end
  end

  always_comb begin
    w_next_ext = w_count_ext;
    case (w_op)
      CLR:  w_next_ext = '0;
      LOAD: w_next_ext = (w_load_ext > MAX_EXT) ? MAX_EXT : w_load_ext;
      STEP: begin
        if (i_up) begin
          if (w_at_max) w_next_ext = (WRAP == MODE_WRAP) ? '0 : MAX_EXT;
          else          w_next_ext = w_count_ext + EW'(1);
        end else begin
          if (w_at_zero) w_next_ext = (WRAP == MODE_WRAP) ? MAX_EXT : '0;
          else           w_next_ext = w_count_ext - EW'(1);
        end
      end
      default: w_next_ext = w_count_ext;
    endcase
  end

  assign o_next = WIDTH'(w_next_ext);
  assign o_tc   = i_rst_n && (w_op == STEP) && ((i_up && w_at_max) || (!i_up && w_at_zero));

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, clear, zero-latency boundary indicator and
// sticky overflow flag. Define MOD_COUNTER_ASSERT_EN to compile embedded assertions.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned MAX   = 15,
  parameter int unsigned WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (MAX == 0 || (MAX >> WIDTH) != 0 || WRAP > MODE_WRAP) begin : g_param_check
    $error("mod_counter: illegal WIDTH/MAX/WRAP combination");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic [WIDTH-1:0] w_next;
  logic             w_tc;

  mod_counter_next #(
    .WIDTH (WIDTH),
    .MAX   (MAX),
    .WRAP  (WRAP)
  ) u_next (
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_up       (up),
    .i_clr      (clr),
    .i_load     (load),
    .i_count    (r_count),
    .i_load_val (load_val),
    .o_next     (w_next),
    .o_tc       (w_tc)
  );

  // A boundary event in the same cycle as a clear request leaves ovf set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      if (w_tc)                r_ovf <= 1'b1;
      else if (ovf_clr || clr) r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign tc    = w_tc;

`ifdef MOD_COUNTER_ASSERT_EN
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] TC_UP  = (WRAP == MODE_WRAP) ? '0 : MAX_W;
  localparam logic [WIDTH-1:0] TC_DN  = (WRAP == MODE_WRAP) ? MAX_W : '0;

  a_range: assert property (@(posedge clk) disable iff (!rst_n) r_count <= MAX_W);

  a_reset: assert property (@(posedge clk) !rst_n |=> (r_count == '0 && !r_ovf));

  a_tc_next: assert property (@(posedge clk) disable iff (!rst_n)
    w_tc |=> (r_count == ($past(up) ? TC_UP : TC_DN)));

  a_step_legal: assert property (@(posedge clk) disable iff (!rst_n)
    ($past(rst_n) && r_count != $past(r_count)) |->
      ($past(clr) || $past(load) ||
       r_count == WIDTH'($past(r_count) + 1'b1) ||
       r_count == WIDTH'($past(r_count) - 1'b1) ||
       r_count == '0 || r_count == MAX_W));
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: three configurations (wrap, saturate,
// WIDTH=4 full-range) share stimulus and are compared against an arithmetic model.
module tb_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, up, clr, load, ovf_clr;
  logic [5:0] load_val;
  logic [3:0] load_val4;
  logic [5:0] count0, count1;
  logic [3:0] count2;
  logic       tc0, tc1, tc2, ovf0, ovf1, ovf2;

  assign load_val4 = load_val[3:0];

  mod_counter u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(count0), .tc(tc0), .ovf(ovf0)
  );

  mod_counter #(.WIDTH(6), .MAX(15), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ovf_clr(ovf_clr), .count(count1), .tc(tc1), .ovf(ovf1)
  );

  mod_counter #(.WIDTH(4), .MAX(15), .WRAP(1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val4), .ovf_clr(ovf_clr), .count(count2), .tc(tc2), .ovf(ovf2)
  );

  localparam int MAXV[3]  = '{15, 15, 15};
  localparam int WRAPV[3] = '{1, 0, 1};
  localparam int LMASK[3] = '{63, 63, 15};

  int n_cmp  = 0;
  int n_fail = 0;
  int m_count[3];
  bit m_ovf[3];
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_tc(input int k, input int c);
    return rst_n && en && !clr && !load &&
           ((up && c == MAXV[k]) || (!up && c == 0));
  endfunction

  function automatic int model_next(input int k, input int c);
    int lv;
    if (clr) return 0;
    if (load) begin
      lv = int'(load_val) & LMASK[k];
      return (lv > MAXV[k]) ? MAXV[k] : lv;
    end
    if (!en) return c;
    if (WRAPV[k] == 1)
      return up ? (c + 1) % (MAXV[k] + 1) : (c + MAXV[k]) % (MAXV[k] + 1);
    return up ? ((c < MAXV[k]) ? c + 1 : c) : ((c > 0) ? c - 1 : 0);
  endfunction

  // Reference model state advance
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_count[k] <= 0;
        m_ovf[k]   <= 1'b0;
      end else begin
        m_count[k] <= model_next(k, m_count[k]);
        m_ovf[k]   <= model_tc(k, m_count[k]) ? 1'b1 : ((ovf_clr || clr) ? 1'b0 : m_ovf[k]);
      end
    end
    if (!rst_n) chk_on <= 1'b1;
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("wrap.count", int'(count0), m_count[0]);
      chk("wrap.tc",    int'(tc0),    int'(model_tc(0, m_count[0])));
      chk("wrap.ovf",   int'(ovf0),   int'(m_ovf[0]));
      chk("sat.count",  int'(count1), m_count[1]);
      chk("sat.tc",     int'(tc1),    int'(model_tc(1, m_count[1])));
      chk("sat.ovf",    int'(ovf1),   int'(m_ovf[1]));
      chk("w4.count",   int'(count2), m_count[2]);
      chk("w4.tc",      int'(tc2),    int'(model_tc(2, m_count[2])));
      chk("w4.ovf",     int'(ovf2),   int'(m_ovf[2]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; up = 1'b0; clr = 1'b0; load = 1'b0;
    ovf_clr = 1'b0; load_val = '0;
    cyc(); cyc();
    #1;
    chk("rst.count", int'(count0), 0);
    chk("rst.ovf",   int'(ovf0),   0);
    chk("rst.tc",    int'(tc0),    0);

    // Count 0..15 then wrap
    rst_n = 1'b1; up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("up16.count", int'(count0), i);
      chk("up16.tc",    int'(tc0),    (i == 15) ? 1 : 0);
      cyc();
    end
    chk("up16.wrap",    int'(count0), 0);
    chk("up16.ovf",     int'(ovf0),   1);
    chk("w4.wrap",      int'(count2), 0);
    chk("w4.ovf",       int'(ovf2),   1);
    chk("sat.hold_max", int'(count1), 15);

    // Load clamps above MAX; clr beats load
    load = 1'b1; load_val = 6'd40;
    cyc();
    chk("load.clamp", int'(count0), 15);
    chk("load.w4",    int'(count2), 8);
    clr = 1'b1;
    cyc();
    chk("clr.count", int'(count0), 0);
    chk("clr.ovf",   int'(ovf0),   0);

    // Saturating down from 0
    clr = 1'b0; load = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat.dn.tc", int'(tc1), 1);
      cyc();
      chk("sat.dn.count", int'(count1), 0);
    end
    chk("sat.dn.ovf", int'(ovf1),   1);
    chk("wrap.dn",    int'(count0), 13);

    // tc beats ovf_clr, then ovf_clr alone clears
    ovf_clr = 1'b1;
    #1;
    chk("ovfclr.tc", int'(tc1), 1);
    cyc();
    chk("ovfclr.keep", int'(ovf1), 1);
    en = 1'b0;
    #1;
    chk("ovfclr.notc", int'(tc1), 0);
    cyc();
    chk("ovfclr.clear", int'(ovf1), 0);

    // Reset mid-count and resume
    ovf_clr = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    repeat (9) cyc();
    chk("mid.count9", int'(count0), 9);
    rst_n = 1'b0;
    #1;
    chk("mid.tc", int'(tc0), 0);
    cyc();
    chk("mid.count", int'(count0), 0);
    chk("mid.ovf",   int'(ovf0),   0);
    rst_n = 1'b1;
    cyc();
    chk("mid.resume1", int'(count0), 1);
    cyc();
    chk("mid.resume2", int'(count0), 2);

    // Randomized traffic
    repeat (3000) begin
      rst_n    = ($urandom_range(0, 99) >= 2);
      clr      = ($urandom_range(0, 99) < 4);
      load     = ($urandom_range(0, 99) < 8);
      ovf_clr  = ($urandom_range(0, 99) < 10);
      en       = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 10) up = ~up;
      load_val = 6'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
